hazard_unit_pipe: RTL
=====================

// Module: hazard_unit_pipe
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage pipeline; sits beside the datapath
//  and drives the pipeline-register enables and flushes. Performs N-deep forwarding with youngest-
//  wins priority, load-use bubble insertion, data-memory wait freezing, and multi-cycle branch flush.
//  Stall/flush sequencing is a registered FSM; forwarding selects are combinational.
// PARAMETERS
//  REG_AW      5   register address width
//  FWD_DEPTH   2   downstream forwarding slots (slot0=EX/MEM, slot1=MEM/WB, ...), range 1..3
//  BR_PENALTY  1   cycles of IF/ID flush after a taken branch, range 1..4
//  CNT_W       16  performance counter width (HAZARD_PERF_EN only)
// PORTS
//  CLK         in   1                 clock, rising edge
//  nRST        in   1                 asynchronous reset, active-low
//  ex_rs       in   REG_AW            rs of the instruction in EX
//  ex_rt       in   REG_AW            rt of the instruction in EX
//  id_rs       in   REG_AW            rs of the instruction in ID
//  id_rt       in   REG_AW            rt of the instruction in ID
//  ex_memread  in   1                 instruction in EX is a load
//  ex_wsel     in   REG_AW            destination register of the instruction in EX
//  fwd_wen     in   FWD_DEPTH         RegWrite per forwarding slot
//  fwd_wsel    in   FWD_DEPTH*REG_AW  destination per slot; slot k is at [k*REG_AW +: REG_AW]
//  br_taken    in   1                 taken branch/jump resolved in EX
//  ihit        in   1                 instruction fetch complete
//  dmem_req    in   1                 MEM stage has a data access outstanding
//  dhit        in   1                 data access complete
//  forwardA    out  FW                FW=$clog2(FWD_DEPTH+1); 0=regfile, k=slot k-1
//  forwardB    out  FW                as forwardA, for rt
//  pc_en, ifid_en, idex_en, exmem_en, memwb_en   out 1 each   pipeline-register enables
//  ifid_flush, idex_flush                        out 1 each   insert bubble (sync clear)
//  hz_state    out  2                 FSM state: 0=RUN, 1=MEM_WAIT, 2=FLUSH
// BEHAVIOUR
//  - Reset (nRST=0, async): state RUN, flush counter 0; all *_en=0, flushes=0, forwardA/B=0.
//  - Forwarding, every cycle: slot k matches rs if fwd_wen[k] && wsel[k]!=0 && wsel[k]==ex_rs.
//    The lowest matching k wins; forwardA=k+1, else 0. Same rule for rt/forwardB. 0-cycle latency.
//  - Outputs are combinational from state and inputs; state/counters update on CLK rising edge.
//  - Default in RUN: all en=1, flushes=0. Rules are applied in priority order, first match wins:
//    1 dmem_req && !dhit: all en=0 -> MEM_WAIT.
//    2 br_taken: pc_en=1, ifid_flush=1, idex_flush=1. If BR_PENALTY>1, load cnt=BR_PENALTY-1
//      and go to FLUSH.
//    3 load-use (ex_memread && ex_wsel!=0 && ex_wsel in {id_rs,id_rt}): pc_en=0, ifid_en=0,
//      idex_flush=1; stay RUN. This inserts exactly one bubble.
//    4 !ihit: pc_en=0, ifid_flush=1; rest advance.
//  - MEM_WAIT: all en=0 while !dhit. On dhit, apply RUN rules 2-4 in the same cycle with the
//    default en=1, then go to RUN or FLUSH. br_taken held through the freeze is honoured here.
//  - FLUSH: ifid_flush=1, other en=1. cnt decrements only when ihit=1; at cnt==1 && ihit, go to RUN.
//    dmem_req && !dhit in FLUSH freezes all stages and holds cnt; the FSM stays in FLUSH.
//  - Reset asserted mid-stall or mid-flush aborts to RUN immediately; no pending state survives.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W], both reset to 0.
//    stall_cnt increments on each cycle with pc_en==0; flush_cnt on each cycle with idex_flush||ifid_flush.
//    Both saturate at all-ones.
//  HAZARD_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 FWD_DEPTH=2, slot0 wsel=3 wen=1, slot1 wsel=3 wen=1, ex_rs=3 -> forwardA=1 (youngest wins);
//    clear slot0 wen -> forwardA=2; wsel=0 -> forwardA=0.
//  2 ex_memread=1, ex_wsel=5, id_rt=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle
//    all en=1.
//  3 dmem_req=1, dhit=0 for 3 cycles -> all en=0 for 3 cycles, hz_state=1; dhit=1 -> all en=1,
//    hz_state=0 next.
//  4 BR_PENALTY=3, br_taken=1 -> cycle0 ifid_flush and idex_flush; then ifid_flush for 2 ihit
//    cycles (ihit=0 gap extends it); then RUN.
//  5 br_taken=1 held during MEM_WAIT -> flush asserted in the dhit cycle, not before.
//  6 nRST low during FLUSH -> outputs 0 immediately; after release, hz_state=0 and (PERF) counters=0.

Source files
------------

// File: rtl/hazard_unit_pipe.sv
// rtl/hazard_unit_pipe.sv - hazard/forwarding controller for the 5-stage pipeline
//
// Purpose: drives pipeline-register enables and flushes beside the datapath.
//   Forwarding selects are combinational with youngest-slot priority.
//   Stall/flush sequencing uses a registered FSM (RUN, MEM_WAIT, FLUSH).
//   Enable and flush outputs are combinational from state and inputs.
//
// Optional feature macro: HAZARD_PERF_EN adds the stall_cnt/flush_cnt
//   saturating performance counters.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   ex_rs, ex_rt         source registers of the instruction in EX
//   id_rs, id_rt         source registers of the instruction in ID
//   ex_memread, ex_wsel  EX holds a load / EX destination register
//   fwd_wen, fwd_wsel    RegWrite and destination per forwarding slot (slot0 youngest)
//   br_taken             taken branch/jump resolved in EX
//   ihit                 instruction fetch complete
//   dmem_req, dhit       MEM data access outstanding / complete
//   forwardA, forwardB   0=regfile, k=slot k-1
//   pc_en..memwb_en      pipeline-register enables
//   ifid_flush, idex_flush  bubble insertion
//   hz_state             0=RUN, 1=MEM_WAIT, 2=FLUSH
//   stall_cnt, flush_cnt performance counters (HAZARD_PERF_EN only)
module hazard_unit_pipe #(
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16,
  localparam int FW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [REG_AW-1:0]           ex_rs,
  input  logic [REG_AW-1:0]           ex_rt,
  input  logic [REG_AW-1:0]           id_rs,
  input  logic [REG_AW-1:0]           id_rt,
  input  logic                        ex_memread,
  input  logic [REG_AW-1:0]           ex_wsel,
  input  logic [FWD_DEPTH-1:0]        fwd_wen,
  input  logic [FWD_DEPTH*REG_AW-1:0] fwd_wsel,
  input  logic                        br_taken,
  input  logic                        ihit,
  input  logic                        dmem_req,
  input  logic                        dhit,
  output logic [FW-1:0]               forwardA,
  output logic [FW-1:0]               forwardB,
  output logic                        pc_en,
  output logic                        ifid_en,
  output logic                        idex_en,
  output logic                        exmem_en,
  output logic                        memwb_en,
  output logic                        ifid_flush,
  output logic                        idex_flush,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt,
`endif
  output logic [1:0]                  hz_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [2:0]  cnt, next_cnt;
  logic        load_use;
  logic        freeze;
  logic [REG_AW-1:0] slot_wsel;

  // Iterate from the oldest slot down so the youngest match overwrites.
  always_comb begin
    forwardA  = '0;
    forwardB  = '0;
    slot_wsel = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      slot_wsel = fwd_wsel[k*REG_AW +: REG_AW];
      if (fwd_wen[k] && slot_wsel != '0 && slot_wsel == ex_rs)
        forwardA = FW'(k + 1);
      if (fwd_wen[k] && slot_wsel != '0 && slot_wsel == ex_rt)
        forwardB = FW'(k + 1);
    end
    if (!nRST) begin
      forwardA = '0;
      forwardB = '0;
    end
  end

  assign load_use = ex_memread && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

  // In RUN a miss needs an outstanding request; once in MEM_WAIT the freeze
  // holds purely until dhit arrives.
  assign freeze = (state == S_MEM_WAIT) ? !dhit : (dmem_req && !dhit);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (nRST) begin
      case (state)
        S_RUN, S_MEM_WAIT: begin
          if (freeze) begin
            next_state = S_MEM_WAIT;
          end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            next_state = S_RUN;
            if (br_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              if (BR_PENALTY > 1) begin
                next_cnt   = 3'(BR_PENALTY - 1);
                next_state = S_FLUSH;
              end
            end else if (load_use) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end else if (!ihit) begin
              pc_en      = 1'b0;
              ifid_flush = 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // A data miss freezes everything and holds the penalty count.
          if (!(dmem_req && !dhit)) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            if (ihit) begin
              if (cnt == 3'd1) begin
                next_cnt   = 3'd0;
                next_state = S_RUN;
              end else begin
                next_cnt = cnt - 3'd1;
              end
            end
          end
        end
        default: next_state = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  assign hz_state = nRST ? state : 2'd0;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if ((ifid_flush || idex_flush) && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
